// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer arbiter: grant states,
// the posted-write entry and the linear pixel-address function.
package fb_pkg;
  localparam int unsigned FB_COLOR_BITS = 6;
  localparam int unsigned FB_H_WIDTH    = 200;
  localparam int unsigned FB_V_WIDTH    = 600;
  localparam int unsigned FB_ADDR_BITS  = $clog2(FB_H_WIDTH * FB_V_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } grant_t;

  typedef struct packed {
    logic [FB_ADDR_BITS-1:0]  addr;
    logic [FB_COLOR_BITS-1:0] data;
  } wr_entry_t;

  function automatic int unsigned fb_addr(input int unsigned h,
                                          input int unsigned v,
                                          input int unsigned h_width);
    return v * h_width + h;
  endfunction
endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle between the arbiter (slave) and its environment (master):
// scan-out request/return, host write port and the single-port RAM.
interface fb_mem_arbiter_if #(
  parameter int unsigned H_BITS     = 9,
  parameter int unsigned V_BITS     = 10,
  parameter int unsigned COLOR_BITS = 6,
  parameter int unsigned ADDR_BITS  = 17
);
  logic                  disp_req;
  logic [H_BITS-1:0]     disp_h;
  logic [V_BITS-1:0]     disp_v;
  logic [COLOR_BITS-1:0] disp_data;
  logic                  disp_valid;
  logic                  host_valid;
  logic                  host_ready;
  logic [H_BITS-1:0]     host_h;
  logic [V_BITS-1:0]     host_v;
  logic [COLOR_BITS-1:0] host_wdata;
  logic                  host_idle;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic [COLOR_BITS-1:0] ram_wdata;
  logic [COLOR_BITS-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_h, disp_v, host_valid, host_h, host_v, host_wdata, ram_rdata,
    output disp_data, disp_valid, host_ready, host_idle, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output disp_req, disp_h, disp_v, host_valid, host_h, host_v, host_wdata, ram_rdata,
    input  disp_data, disp_valid, host_ready, host_idle, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Posted host-write FIFO with first-word-fall-through head; FIFO_DEPTH is a
// power of two so the pointers wrap naturally.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t wdata,
  output logic      full,
  output logic      empty,
  output wr_entry_t head
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  wr_entry_t        mem_q [FIFO_DEPTH];
  wr_entry_t        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage holds data only; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer RAM arbiter: scan-out reads have strict priority, host writes
// are posted and drained on idle cycles. FB_ARB_STATS_EN adds drop/stall counters.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned H_WIDTH    = 200,
  parameter int unsigned V_WIDTH    = 600,
  parameter int unsigned H_BITS     = 9,
  parameter int unsigned V_BITS     = 10,
  parameter int unsigned COLOR_BITS = FB_COLOR_BITS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FB_ARB_STATS_EN
  output logic [15:0] drop_cnt,
  output logic [15:0] stall_cnt,
`endif
  fb_mem_arbiter_if.slave bus
);
  localparam int unsigned ADDR_BITS = $clog2(H_WIDTH * V_WIDTH);

  grant_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
  logic [COLOR_BITS-1:0] ram_wdata_q, ram_wdata_d;
  logic                  rd_en_q, rd_en_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  inr_p1_q, inr_p1_d;
  logic                  disp_valid_q, disp_valid_d;
  logic [COLOR_BITS-1:0] disp_data_q, disp_data_d;

  logic [H_BITS-1:0]     disp_h, host_h;
  logic [V_BITS-1:0]     disp_v, host_v;
  logic [ADDR_BITS-1:0]  disp_addr, host_addr;
  logic                  disp_inr, host_inr;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  wr_entry_t             push_entry, head_entry;

  assign disp_h    = bus.disp_h;
  assign disp_v    = bus.disp_v;
  assign host_h    = bus.host_h;
  assign host_v    = bus.host_v;
  assign disp_inr  = (32'(disp_h) < H_WIDTH) && (32'(disp_v) < V_WIDTH);
  assign host_inr  = (32'(host_h) < H_WIDTH) && (32'(host_v) < V_WIDTH);
  assign disp_addr = ADDR_BITS'(fb_addr(32'(disp_h), 32'(disp_v), H_WIDTH));
  assign host_addr = ADDR_BITS'(fb_addr(32'(host_h), 32'(host_v), H_WIDTH));

  // Out-of-range host writes are acknowledged but never enter the FIFO.
  assign fifo_push = bus.host_valid & ~fifo_full & host_inr;
  assign fifo_pop  = (state_d == WR);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = FB_ADDR_BITS'(host_addr);
    push_entry.data = FB_COLOR_BITS'(bus.host_wdata);
  end

  fb_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_entry)
  );

  always_comb begin
    state_d = IDLE;
    if (bus.disp_req)     state_d = RD;
    else if (!fifo_empty) state_d = WR;
  end

  // Stage 0: address/data registered alongside the grant state.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_en_d     = 1'b0;
    unique case (state_d)
      RD: begin
        ram_addr_d = disp_addr;
        rd_en_d    = disp_inr;
      end
      WR: begin
        ram_addr_d  = ADDR_BITS'(head_entry.addr);
        ram_wdata_d = COLOR_BITS'(head_entry.data);
      end
      default: ;
    endcase
  end

  // Stage 1: RAM returns data; stage 2: result registered for scan-out.
  always_comb begin
    vld_p1_d     = (state_q == RD);
    inr_p1_d     = rd_en_q;
    disp_valid_d = vld_p1_q;
    disp_data_d  = (vld_p1_q && inr_p1_q) ? bus.ram_rdata : disp_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_en_q      <= 1'b0;
      vld_p1_q     <= 1'b0;
      inr_p1_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_en_q      <= rd_en_d;
      vld_p1_q     <= vld_p1_d;
      inr_p1_q     <= inr_p1_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  always_comb begin
    bus.ram_en    = ((state_q == RD) && rd_en_q) || (state_q == WR);
    bus.ram_we    = (state_q == WR);
    bus.host_idle = fifo_empty && (state_q != WR);
  end

  assign bus.host_ready = ~fifo_full;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
  endfunction

  always_comb begin
    drop_cnt_d  = sat_inc(drop_cnt_q, bus.host_valid & ~fifo_full & ~host_inr);
    stall_cnt_d = sat_inc(stall_cnt_q, bus.disp_req & ~fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: RAM model, read/write scoreboards,
// a table of scan-out vectors and hand sequences for priority/backpressure/reset.
module tb_fb_mem_arbiter;
  import fb_pkg::*;

  localparam int unsigned H_BITS     = 9;
  localparam int unsigned V_BITS     = 10;
  localparam int unsigned COLOR_BITS = 6;
  localparam int unsigned ADDR_BITS  = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_mem_arbiter_if #(
    .H_BITS(H_BITS), .V_BITS(V_BITS), .COLOR_BITS(COLOR_BITS), .ADDR_BITS(ADDR_BITS)
  ) bus ();

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt, stall_cnt;
`endif

  fb_mem_arbiter #(
    .H_WIDTH(200), .V_WIDTH(600), .H_BITS(H_BITS), .V_BITS(V_BITS),
    .COLOR_BITS(COLOR_BITS), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FB_ARB_STATS_EN
    .drop_cnt  (drop_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  // Background pattern; mem[405] is preloaded with 0x2A.
  function automatic logic [5:0] pat(input int unsigned a);
    logic [31:0] av;
    av = a;
    return (a == 405) ? 6'h2A : (av[5:0] ^ 6'h15);
  endfunction

  logic [COLOR_BITS-1:0] mem     [1<<ADDR_BITS];
  logic                  written [1<<ADDR_BITS];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr]     <= bus.ram_wdata;
        written[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= (written[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr] : pat(32'(bus.ram_addr));
      end
    end
  end

  typedef struct { logic [5:0] data; int due; } rd_exp_t;
  typedef struct { logic [16:0] addr; logic [5:0] data; } wr_exp_t;
  typedef struct { int h; int v; logic en; logic [16:0] addr; logic [5:0] data; } vec_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  rd_exp_t mon_r;
  wr_exp_t mon_w;
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_disp_data"},  32'(bus.disp_data),  0);
    check({tag, "_disp_valid"}, 32'(bus.disp_valid), 0);
    check({tag, "_host_ready"}, 32'(bus.host_ready), 1);
    check({tag, "_host_idle"},  32'(bus.host_idle),  1);
    check({tag, "_ram_en"},     32'(bus.ram_en),     0);
    check({tag, "_ram_we"},     32'(bus.ram_we),     0);
    check({tag, "_ram_addr"},   32'(bus.ram_addr),   0);
    check({tag, "_ram_wdata"},  32'(bus.ram_wdata),  0);
  endtask

  task automatic set_disp(input logic req, input int h, input int v);
    bus.disp_req = req;
    bus.disp_h   = H_BITS'(h);
    bus.disp_v   = V_BITS'(v);
  endtask

  task automatic set_host(input logic vld, input int h, input int v, input int d);
    bus.host_valid = vld;
    bus.host_h     = H_BITS'(h);
    bus.host_v     = V_BITS'(v);
    bus.host_wdata = COLOR_BITS'(d);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.disp_valid) begin
        if (rq.size() == 0) check("disp_valid_unexpected", 1, 0);
        else begin
          mon_r = rq.pop_front();
          check("disp_data", 32'(bus.disp_data), 32'(mon_r.data));
          check("disp_latency", cyc, mon_r.due);
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        check("disp_valid_missing", 0, 1);
        void'(rq.pop_front());
      end
      if (bus.ram_en && bus.ram_we) begin
        if (wq.size() == 0) check("ram_we_unexpected", 1, 0);
        else begin
          mon_w = wq.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(mon_w.addr));
          check("wr_data", 32'(bus.ram_wdata), 32'(mon_w.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl [9];

  initial begin : main
    int t;
    tbl[0] = '{5,   2,   1'b1, 17'd405,    6'h2A};
    tbl[1] = '{199, 599, 1'b1, 17'd119999, 6'h2A};
    tbl[2] = '{6,   2,   1'b1, 17'd406,    6'h03};
    tbl[3] = '{200, 3,   1'b0, 17'd0,      6'h03};
    tbl[4] = '{0,   600, 1'b0, 17'd0,      6'h03};
    tbl[5] = '{0,   3,   1'b1, 17'd600,    6'h0D};
    tbl[6] = '{511, 1023,1'b0, 17'd0,      6'h0D};
    tbl[7] = '{100, 100, 1'b1, 17'd20100,  6'h11};
    tbl[8] = '{1,   2,   1'b1, 17'd401,    6'h04};

    set_disp(1'b0, 0, 0);
    set_host(1'b0, 0, 0, 0);
    #22;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read: address registered after the sampling edge, data three cycles on.
    @(negedge clk);
    set_disp(1'b1, 5, 2);
    rq.push_back('{6'h2A, cyc + 3});
    @(posedge clk); #1;
    check("lat_ram_en", 32'(bus.ram_en), 1);
    check("lat_ram_we", 32'(bus.ram_we), 0);
    check("lat_ram_addr", 32'(bus.ram_addr), 405);
    @(negedge clk);
    set_disp(1'b0, 0, 0);
    repeat (4) @(negedge clk);

    // Back-to-back table reads, including out-of-range coordinates.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_disp(1'b1, tbl[i].h, tbl[i].v);
      rq.push_back('{tbl[i].data, cyc + 3});
      @(posedge clk); #1;
      check("tbl_ram_en", 32'(bus.ram_en), 32'(tbl[i].en));
      if (tbl[i].en) check("tbl_ram_addr", 32'(bus.ram_addr), 32'(tbl[i].addr));
    end
    @(negedge clk);
    set_disp(1'b0, 0, 0);
    repeat (5) @(negedge clk);

    // Write latency with FIFO empty and no display traffic.
    set_host(1'b1, 10, 0, 'h33);
    check("wl_ready", 32'(bus.host_ready), 1);
    wq.push_back('{17'd10, 6'h33});
    @(posedge clk); #1;
    check("wl_not_yet", 32'(bus.ram_we), 0);
    check("wl_busy", 32'(bus.host_idle), 0);
    @(negedge clk);
    set_host(1'b0, 0, 0, 0);
    @(posedge clk); #1;
    check("wl_ram_we", 32'(bus.ram_we), 1);
    check("wl_ram_addr", 32'(bus.ram_addr), 10);
    check("wl_ram_wdata", 32'(bus.ram_wdata), 'h33);
    check("wl_idle_in_wr", 32'(bus.host_idle), 0);
    @(posedge clk); #1;
    check("wl_idle_after", 32'(bus.host_idle), 1);

    // Priority: one queued write waits out ten display cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_disp(1'b1, 5, 2);
      rq.push_back('{6'h2A, cyc + 3});
      if (k == 0) begin
        set_host(1'b1, 0, 0, 'h11);
        check("pri_ready", 32'(bus.host_ready), 1);
        wq.push_back('{17'd0, 6'h11});
      end else set_host(1'b0, 0, 0, 0);
      @(posedge clk); #1;
      check("pri_no_we", 32'(bus.ram_we), 0);
    end
    @(negedge clk);
    set_disp(1'b0, 0, 0);
    @(posedge clk); #1;
    check("pri_we_after", 32'(bus.ram_we), 1);
    check("pri_addr_after", 32'(bus.ram_addr), 0);
    repeat (4) @(negedge clk);

    // Backpressure: five offers against a depth-4 FIFO under active video.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_disp(1'b1, 5, 2);
      rq.push_back('{6'h2A, cyc + 3});
      set_host(1'b1, k + 1, 1, 'h20 + k);
      check("bp_host_ready", 32'(bus.host_ready), (k < 4) ? 1 : 0);
      if (k < 4) wq.push_back('{17'(201 + k), 6'(32 + k)});
    end
    repeat (3) begin
      @(negedge clk);
      set_host(1'b0, 0, 0, 0);
      set_disp(1'b1, 5, 2);
      rq.push_back('{6'h2A, cyc + 3});
    end
    @(negedge clk);
    set_disp(1'b0, 0, 0);
    t = 0;
    while ((wq.size() != 0 || bus.host_idle !== 1'b1) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("bp_drain_done", (t < 60) ? 1 : 0, 1);
    check("bp_ready_after", 32'(bus.host_ready), 1);
    repeat (4) @(negedge clk);

    // Reset in the middle of reads with two writes queued.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_disp(1'b1, 6, 2);
      rq.push_back('{6'h03, cyc + 3});
      if (k < 2) begin
        set_host(1'b1, k + 20, 0, 'h05 + k);
        check("rst_ready", 32'(bus.host_ready), 1);
        wq.push_back('{17'(20 + k), 6'(5 + k)});
      end else set_host(1'b0, 0, 0, 0);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    rq.delete();
    wq.delete();
    set_disp(1'b0, 0, 0);
    set_host(1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("postrst_idle", 32'(bus.host_idle), 1);
    check("postrst_ready", 32'(bus.host_ready), 1);

    // Out-of-range host write: accepted, never reaches the RAM.
    set_host(1'b1, 200, 0, 'h3F);
    check("oor_ready", 32'(bus.host_ready), 1);
    @(negedge clk);
    set_host(1'b0, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("oor_idle", 32'(bus.host_idle), 1);
`ifdef FB_ARB_STATS_EN
    check("oor_drop_cnt", 32'(drop_cnt), 1);
    check("oor_stall_cnt", 32'(stall_cnt), 0);
`endif

    repeat (5) @(negedge clk);
    check("rd_sb_empty", rq.size(), 0);
    check("wr_sb_empty", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_mem_arbiter.md
# fb_mem_arbiter

Arbiter and sequencer for the single-port frame-buffer RAM in the VGA card. It shares the RAM between the scan-out path, which reads one pixel per request at a fixed latency and always wins, and a host write port, which is posted into a small FIFO and drained only on cycles the scan-out path leaves idle. It sits between the sync/timing generator (pixel coordinates) and the RAM macro, and replaces direct indexing of the pixel memory.

## Interface
- H_WIDTH, 200: pixels per line.
- V_WIDTH, 600: lines per frame.
- H_BITS, 9: width of horizontal coordinates.
- V_BITS, 10: width of vertical coordinates.
- COLOR_BITS, 6: pixel width (R2G2B2).
- FIFO_DEPTH, 4: host write FIFO entries; power of two, at least 2.
- ADDR_BITS (localparam): $clog2(H_WIDTH*V_WIDTH).
- Clocking and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_req  in  1  scan-out wants a pixel this cycle (low during porches and blanking).
- disp_h  in  H_BITS  scan-out column.
- disp_v  in  V_BITS  scan-out line.
- disp_data  out  COLOR_BITS  returned pixel.
- disp_valid  out  1  disp_data is new this cycle.
- host_valid  in  1  host write request.
- host_ready  out  1  FIFO can accept a write.
- host_h  in  H_BITS  host write column.
- host_v  in  V_BITS  host write line.
- host_wdata  in  COLOR_BITS  host pixel.
- host_idle  out  1  FIFO empty and no write in flight.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  the access is a write.
- ram_addr  out  ADDR_BITS  RAM address.
- ram_wdata  out  COLOR_BITS  RAM write data.
- ram_rdata  in  COLOR_BITS  RAM read data, one cycle after ram_en with ram_we=0.

## Operation
- Address: addr = v*H_WIDTH + h, computed at ADDR_BITS width. A coordinate is in range iff h < H_WIDTH and v < V_WIDTH. Each axis is checked on its own, not the sum.
- Grant FSM, registered, three states:
  - IDLE: no access.
  - RD: display read.
  - WR: host write.
  - Next state is RD if disp_req is high. Otherwise WR if the FIFO is non-empty. Otherwise IDLE.
  - The display has strict priority and is never delayed.
- RD with out-of-range coordinates: ram_en=0. disp_valid still fires at the normal latency, and disp_data holds its previous value.
- Host push: on host_valid & host_ready.
  - In-range writes are stored as {addr, data}.
  - Out-of-range writes are accepted but discarded.
- host_ready = !full. There is no pass-through when the FIFO is full.
- The pop happens on entry to WR. Push and pop in the same cycle are both honoured, and the count is unchanged.
- Host writes drain in FIFO order. They can starve indefinitely during active video and drain fully during blanking.
- host_idle = FIFO empty & state != WR.

## Timing
- Reset values:
  - disp_data = 0, disp_valid = 0, host_ready = 1, host_idle = 1.
  - ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - FSM in IDLE, FIFO empty.
- Read latency: disp_req sampled high at edge 0 gives:
  - ram_en=1, ram_we=0 and the address registered after edge 0;
  - ram_rdata valid after edge 1;
  - disp_data/disp_valid registered after edge 2;
  - i.e. disp_valid is high in the third cycle after the request cycle, every time.
- Back-to-back requests return one pixel per cycle.
- Write latency: with the FIFO empty and disp_req low, a push at edge 0 appears as ram_we=1 after edge 1.
- Reset mid-operation:
  - The FIFO is flushed and the pipeline is cleared.
  - Read results still in flight are never emitted.
  - Writes still in the FIFO are lost.

## Configuration
- FB_ARB_STATS_EN defined: adds two outputs, drop_cnt and stall_cnt, both 16-bit, saturating, and cleared by rst.
  - drop_cnt counts discarded out-of-range host writes.
  - stall_cnt counts cycles where the FIFO is non-empty and disp_req is high.
- FB_ARB_STATS_EN undefined: these ports and counters are absent, and all other behaviour is identical.

## Structure
- Package fb_pkg holds:
  - the COLOR_BITS default;
  - the grant-state enum {IDLE, RD, WR};
  - the address-computation function;
  - the write-entry struct {addr, data}.
- Sub-module fb_wr_fifo: a synchronous FIFO with FIFO_DEPTH entries.
  - Ports: push, pop, full, empty, and a first-word-fall-through head.

## Test plan
- Read latency: disp_req=1, (h=5, v=2), RAM preloaded with mem[405]=0x2A → disp_valid=1 and disp_data=0x2A exactly three cycles later; ram_addr=405.
- Priority: FIFO holds one write to (0,0) and disp_req is high for 10 cycles → no ram_we during those cycles; the write is issued in the first cycle after disp_req drops.
- Backpressure: disp_req held high and 5 host writes offered with FIFO_DEPTH=4 → host_ready drops after the 4th write; all 4 drain in order afterwards.
- Out-of-range:
  - host write to h=200 → accepted, no RAM write, drop_cnt=1 (with FB_ARB_STATS_EN);
  - display read at v=600 → disp_valid fires and disp_data holds its previous value.
- Reset: rst asserted mid-read with 2 FIFO entries → all outputs return to reset values immediately and no stale disp_valid appears after release.
